// File: rtl/mismatch_tracker_if.sv
// Control, sample and statistics bundle for mismatch_tracker.
// The master side drives the run controls and the vectors; the slave reports the statistics.
interface mismatch_tracker_if #(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 16
);
  logic               start;
  logic               stop;
  logic               sample;
  logic [N-1:0]       ref_vec;
  logic [N-1:0]       dut_vec;
  logic               busy;
  logic               done;
  logic               fail;
  logic [CNT_W-1:0]   sample_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [N*CNT_W-1:0] bit_err_cnt;
  logic [CNT_W-1:0]   first_err_idx;
  logic [N-1:0]       first_err_bits;

  modport master (
    output start, stop, sample, ref_vec, dut_vec,
    input  busy, done, fail, sample_cnt, err_cnt, bit_err_cnt, first_err_idx, first_err_bits
  );

  modport slave (
    input  start, stop, sample, ref_vec, dut_vec,
    output busy, done, fail, sample_cnt, err_cnt, bit_err_cnt, first_err_idx, first_err_bits
  );
endinterface

// File: rtl/mismatch_tracker.sv
// Compares a reference vector against a checked vector over a start/stop run and keeps
// saturating match statistics plus a snapshot of the first failing sample.
module mismatch_tracker #(
  parameter int unsigned N     = 3,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                aresetn,
  mismatch_tracker_if.slave  bus_io
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // Bit 0 flags RUN and bit 1 flags DONE so busy/done are plain flop outputs.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]            err_cnt_q, err_cnt_d;
  logic [N-1:0][CNT_W-1:0]     bit_err_cnt_q, bit_err_cnt_d;
  logic [CNT_W-1:0]            first_err_idx_q, first_err_idx_d;
  logic [N-1:0]                first_err_bits_q, first_err_bits_d;
  logic                        fail_q, fail_d;

  logic [N-1:0] diff;
  logic         mismatch;
  logic         accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CntMax) ? v : v + CntOne;
  endfunction

  assign diff     = bus_io.ref_vec ^ bus_io.dut_vec;
  assign mismatch = |diff;
  // A restart cycle never counts as a sample, even with sample high.
  assign accept   = (state_q == StRun) && bus_io.sample && !bus_io.start;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) state_d = StRun;
      end
      StRun: begin
        if (bus_io.start)     state_d = StRun;
        else if (bus_io.stop) state_d = StDone;
      end
      StDone: begin
        if (bus_io.start) state_d = StRun;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sample_cnt_d     = sample_cnt_q;
    err_cnt_d        = err_cnt_q;
    bit_err_cnt_d    = bit_err_cnt_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_bits_d = first_err_bits_q;
    fail_d           = fail_q;

    if (bus_io.start) begin
      sample_cnt_d     = '0;
      err_cnt_d        = '0;
      bit_err_cnt_d    = '0;
      first_err_idx_d  = '0;
      first_err_bits_d = '0;
      fail_d           = 1'b0;
    end else if (accept) begin
      sample_cnt_d = sat_inc(sample_cnt_q);
      if (mismatch) begin
        err_cnt_d = sat_inc(err_cnt_q);
        // Snapshot uses the pre-increment index so the first sample of a run is index 0.
        if (!fail_q) begin
          first_err_idx_d  = sample_cnt_q;
          first_err_bits_d = diff;
          fail_d           = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (diff[i]) bit_err_cnt_d[i] = sat_inc(bit_err_cnt_q[i]);
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q          <= StIdle;
      sample_cnt_q     <= '0;
      err_cnt_q        <= '0;
      bit_err_cnt_q    <= '0;
      first_err_idx_q  <= '0;
      first_err_bits_q <= '0;
      fail_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      sample_cnt_q     <= sample_cnt_d;
      err_cnt_q        <= err_cnt_d;
      bit_err_cnt_q    <= bit_err_cnt_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_bits_q <= first_err_bits_d;
      fail_q           <= fail_d;
    end
  end

  assign bus_io.busy           = state_q[0];
  assign bus_io.done           = state_q[1];
  assign bus_io.fail           = fail_q;
  assign bus_io.sample_cnt     = sample_cnt_q;
  assign bus_io.err_cnt        = err_cnt_q;
  assign bus_io.bit_err_cnt    = bit_err_cnt_q;
  assign bus_io.first_err_idx  = first_err_idx_q;
  assign bus_io.first_err_bits = first_err_bits_q;

  a_legal_state: assert property (@(posedge clk) disable iff (!aresetn)
    state_q != 2'b11);
  a_fail_has_err: assert property (@(posedge clk) disable iff (!aresetn)
    fail_q |-> (err_cnt_q != '0));

endmodule

// File: tb/tb_mismatch_tracker.sv
// Drives a 16-bit-counter and a 4-bit-counter tracker with the same stimulus and compares
// both against a behavioural run/statistics model.
module tb_mismatch_tracker;

  localparam int unsigned N = 3;
  localparam int          MIdle = 0;
  localparam int          MRun  = 1;
  localparam int          MDone = 2;

  logic clk;
  logic aresetn;

  mismatch_tracker_if #(.N(N), .CNT_W(16)) bus_w ();
  mismatch_tracker_if #(.N(N), .CNT_W(4))  bus_n ();

  mismatch_tracker #(.N(N), .CNT_W(16)) u_dut_w (.clk(clk), .aresetn(aresetn), .bus_io(bus_w));
  mismatch_tracker #(.N(N), .CNT_W(4))  u_dut_n (.clk(clk), .aresetn(aresetn), .bus_io(bus_n));

  int unsigned n_vec;
  int unsigned n_miss;

  // Reference model: index 0 tracks the 16-bit instance, index 1 the 4-bit instance.
  int          m_mode;
  int unsigned m_max   [2];
  int unsigned m_samp  [2];
  int unsigned m_err   [2];
  int unsigned m_bit   [2][N];
  int unsigned m_fidx  [2];
  logic [N-1:0] m_fbits [2];
  bit          m_fail  [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_samp[k] = 0; m_err[k] = 0; m_fidx[k] = 0; m_fbits[k] = '0; m_fail[k] = 1'b0;
      for (int i = 0; i < N; i++) m_bit[k][i] = 0;
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle;
    model_clear();
  endtask

  function automatic int unsigned sat(input int unsigned v, input int k);
    return (v < m_max[k]) ? v + 1 : v;
  endfunction

  task automatic model_accept(input logic [N-1:0] diff);
    for (int k = 0; k < 2; k++) begin
      if (diff != '0 && !m_fail[k]) begin
        m_fidx[k] = m_samp[k]; m_fbits[k] = diff; m_fail[k] = 1'b1;
      end
      m_samp[k] = sat(m_samp[k], k);
      if (diff != '0) m_err[k] = sat(m_err[k], k);
      for (int i = 0; i < N; i++) if (diff[i]) m_bit[k][i] = sat(m_bit[k][i], k);
    end
  endtask

  task automatic model_step(input bit st, input bit sp, input bit smp,
                            input logic [N-1:0] r, input logic [N-1:0] d);
    if (st) begin
      model_clear();
      m_mode = MRun;
    end else if (m_mode == MRun) begin
      if (smp) model_accept(r ^ d);
      if (sp) m_mode = MDone;
    end
  endtask

  task automatic check_inst(input int k, input string p, input logic busy, input logic done,
                            input logic fail, input logic [63:0] sc, input logic [63:0] ec,
                            input logic [63:0] be, input logic [63:0] fi,
                            input logic [N-1:0] fb);
    int cw;
    logic [63:0] mask;
    cw   = (k == 0) ? 16 : 4;
    mask = (64'd1 << cw) - 64'd1;
    check_eq({p, ".busy"}, 64'(busy), 64'(m_mode == MRun));
    check_eq({p, ".done"}, 64'(done), 64'(m_mode == MDone));
    check_eq({p, ".fail"}, 64'(fail), 64'(m_fail[k]));
    check_eq({p, ".sample_cnt"}, sc, 64'(m_samp[k]));
    check_eq({p, ".err_cnt"}, ec, 64'(m_err[k]));
    for (int i = 0; i < N; i++)
      check_eq($sformatf("%s.bit_err_cnt[%0d]", p, i), (be >> (i * cw)) & mask,
               64'(m_bit[k][i]));
    check_eq({p, ".first_err_idx"}, fi, 64'(m_fidx[k]));
    check_eq({p, ".first_err_bits"}, 64'(fb), 64'(m_fbits[k]));
  endtask

  task automatic check_all();
    check_inst(0, "w", bus_w.busy, bus_w.done, bus_w.fail, 64'(bus_w.sample_cnt),
               64'(bus_w.err_cnt), 64'(bus_w.bit_err_cnt), 64'(bus_w.first_err_idx),
               bus_w.first_err_bits);
    check_inst(1, "n", bus_n.busy, bus_n.done, bus_n.fail, 64'(bus_n.sample_cnt),
               64'(bus_n.err_cnt), 64'(bus_n.bit_err_cnt), 64'(bus_n.first_err_idx),
               bus_n.first_err_bits);
  endtask

  // Apply one cycle of stimulus to both instances, then check just after the edge.
  task automatic cycle(input bit st, input bit sp, input bit smp,
                       input logic [N-1:0] r, input logic [N-1:0] d);
    bus_w.start = st; bus_w.stop = sp; bus_w.sample = smp; bus_w.ref_vec = r; bus_w.dut_vec = d;
    bus_n.start = st; bus_n.stop = sp; bus_n.sample = smp; bus_n.ref_vec = r; bus_n.dut_vec = d;
    @(posedge clk);
    model_step(st, sp, smp, r, d);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    aresetn = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    m_max[0] = 65535; m_max[1] = 15;
    aresetn = 1'b0;
    bus_w.start = 1'b0; bus_w.stop = 1'b0; bus_w.sample = 1'b0;
    bus_w.ref_vec = '0; bus_w.dut_vec = '0;
    bus_n.start = 1'b0; bus_n.stop = 1'b0; bus_n.sample = 1'b0;
    bus_n.ref_vec = '0; bus_n.dut_vec = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    aresetn = 1'b1;

    // Clean run of ten matching samples.
    cycle(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 10; i++) cycle(0, 0, 1, 3'b101, 3'b101);
    cycle(0, 1, 0, 3'b000, 3'b000);
    check_eq("clean.done", 64'(bus_w.done), 64'd1);
    check_eq("clean.sample_cnt", 64'(bus_w.sample_cnt), 64'd10);
    check_eq("clean.err_cnt", 64'(bus_w.err_cnt), 64'd0);

    // First-error snapshot and per-bit counts.
    cycle(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 3'b011, 3'b011);
    cycle(0, 0, 1, 3'b110, 3'b100);
    cycle(0, 0, 1, 3'b000, 3'b111);
    cycle(0, 1, 0, 3'b000, 3'b000);
    check_eq("snap.err_cnt", 64'(bus_w.err_cnt), 64'd2);
    check_eq("snap.fail", 64'(bus_w.fail), 64'd1);
    check_eq("snap.first_err_idx", 64'(bus_w.first_err_idx), 64'd5);
    check_eq("snap.first_err_bits", 64'(bus_w.first_err_bits), 64'b010);
    check_eq("snap.bit_err_cnt", 64'(bus_w.bit_err_cnt), {16'd0, 16'd1, 16'd2, 16'd1});

    // Sample together with stop is counted; samples in DONE are ignored.
    cycle(1, 0, 0, 3'b000, 3'b000);
    cycle(0, 0, 1, 3'b001, 3'b001);
    cycle(0, 0, 1, 3'b001, 3'b001);
    cycle(0, 1, 1, 3'b011, 3'b001);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'b111, 3'b000);
    check_eq("stopsamp.done", 64'(bus_w.done), 64'd1);
    check_eq("stopsamp.sample_cnt", 64'(bus_w.sample_cnt), 64'd3);
    check_eq("stopsamp.err_cnt", 64'(bus_w.err_cnt), 64'd1);

    // Restart while failed: start beats stop and the sample is dropped.
    cycle(1, 0, 0, 3'b000, 3'b000);
    cycle(0, 0, 1, 3'b100, 3'b000);
    cycle(1, 1, 1, 3'b111, 3'b000);
    check_eq("restart.busy", 64'(bus_w.busy), 64'd1);
    check_eq("restart.fail", 64'(bus_w.fail), 64'd0);
    check_eq("restart.sample_cnt", 64'(bus_w.sample_cnt), 64'd0);

    // Saturation on the narrow instance.
    cycle(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 3'b001, 3'b000);
    check_eq("sat.sample_cnt", 64'(bus_n.sample_cnt), 64'd15);
    check_eq("sat.err_cnt", 64'(bus_n.err_cnt), 64'd15);
    check_eq("sat.bit_err_cnt", 64'(bus_n.bit_err_cnt), 64'h00f);
    check_eq("sat.first_err_idx", 64'(bus_n.first_err_idx), 64'd0);
    check_eq("sat.wide_sample_cnt", 64'(bus_w.sample_cnt), 64'd20);

    // Asynchronous reset mid-run, then samples without start stay ignored.
    cycle(1, 0, 0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'b010, 3'b000);
    check_eq("areset.pre_err_cnt", 64'(bus_w.err_cnt), 64'd3);
    async_reset();
    check_eq("areset.err_cnt", 64'(bus_w.err_cnt), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 3'b010, 3'b000);
    check_eq("areset.idle_busy", 64'(bus_w.busy), 64'd0);
    check_eq("areset.idle_sample_cnt", 64'(bus_w.sample_cnt), 64'd0);

    // Randomized traffic with occasional restarts, stops and one mid-stream reset.
    for (int c = 0; c < 600; c++) begin
      bit st, sp, smp;
      logic [N-1:0] r, d;
      st  = ($urandom_range(0, 99) < 4);
      sp  = ($urandom_range(0, 99) < 4);
      smp = ($urandom_range(0, 99) < 65);
      r   = N'($urandom);
      d   = ($urandom_range(0, 1) == 1) ? r : (r ^ N'($urandom));
      cycle(st, sp, smp, r, d);
      if (c == 300) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
